// File: rtl/spec_reg_pkg.sv
`default_nettype none
// spec_reg_pkg: command encodings, flag bit positions and helpers shared by
// the special-register flag stack and its saved-context LIFO.
package spec_reg_pkg;

  localparam int FLAG_W = 5;

  localparam int FLG_N = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_M = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [2:0] {
    UPD_HOLD   = 3'd0,
    UPD_BS     = 3'd1,
    UPD_ALU    = 3'd2,
    UPD_MOV    = 3'd3,
    UPD_OVF    = 3'd4,
    UPD_TRAP   = 3'd5,
    UPD_HALT   = 3'd6,
    UPD_RETURN = 3'd7
  } upd_mode_e;

  // Address width of a DEPTH-entry array; a single entry still needs one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_lifo.sv
`default_nettype none
// flag_lifo: DEPTH-entry LIFO of saved flag vectors, updated on the falling
// clock edge. Pushes when full and pops when empty are refused.
module flag_lifo
  import spec_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  flags_t           push_data_i,
  output flags_t           pop_data_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic             pop_ok_o
);

  localparam int IDX_W = idx_width(DEPTH);

  flags_t             mem_q [DEPTH];
  logic [CNT_W-1:0]   depth_q;
  logic [CNT_W-1:0]   depth_d;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign full_o    = (depth_q == CNT_W'(DEPTH));
  assign empty_o   = (depth_q == '0);
  assign push_ok_o = push_i & ~full_o;
  assign pop_ok_o  = pop_i & ~empty_o & ~push_i;

  // The top entry sits one below the occupancy count; modular arithmetic on
  // the low bits is exact because the count never exceeds DEPTH.
  assign wr_idx = depth_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);

  assign pop_data_o = mem_q[rd_idx];
  assign depth_o    = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push_ok_o) begin
      depth_d = depth_q + CNT_W'(1);
    end else if (pop_ok_o) begin
      depth_d = depth_q - CNT_W'(1);
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  // Storage survives reset; only the occupancy count is cleared.
  always_ff @(negedge clock) begin
    if (push_ok_o) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spec_reg_stack.sv
`default_nettype none
// spec_reg_stack: N/Z/C/V/M special register with trap save/restore LIFO,
// direct load path and sticky stack-fault status. Updates on falling edge.
module spec_reg_stack
  import spec_reg_pkg::*;
#(
  parameter int             DEPTH       = 4,
  parameter logic [4:0]     RESET_FLAGS = 5'b00000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   update_mode,
  input  logic                         wr_en,
  input  logic [4:0]                   wr_data,
  input  logic                         alu_negative,
  input  logic                         alu_zero,
  input  logic                         alu_carry,
  input  logic                         alu_overflow,
  input  logic                         bs_negative,
  input  logic                         bs_zero,
  input  logic                         bs_carry,
  output logic                         negative_flag,
  output logic                         zero_flag,
  output logic                         carry_flag,
  output logic                         overflow_flag,
  output logic                         mode_flag,
  output logic [4:0]                   flags,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         stack_fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  flags_t           flags_q;
  flags_t           flags_d;
  logic             fault_q;
  logic             fault_d;
  logic             push_req;
  logic             pop_req;
  flags_t           pop_data;
  logic [CNT_W-1:0] lifo_depth;
  logic             lifo_full;
  logic             lifo_empty;
  logic             lifo_push_ok;
  logic             lifo_pop_ok;

  flag_lifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_lifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push_req),
    .pop_i       (pop_req),
    .push_data_i (flags_q),
    .pop_data_o  (pop_data),
    .depth_o     (lifo_depth),
    .full_o      (lifo_full),
    .empty_o     (lifo_empty),
    .push_ok_o   (lifo_push_ok),
    .pop_ok_o    (lifo_pop_ok)
  );

  // A direct write masks the command entirely, including any stack access.
  always_comb begin
    flags_d  = flags_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (wr_en) begin
      flags_d = wr_data;
    end else begin
      case (upd_mode_e'(update_mode))
        UPD_HOLD: ;
        UPD_BS: begin
          flags_d[FLG_N] = bs_negative;
          flags_d[FLG_Z] = bs_zero;
          flags_d[FLG_C] = bs_carry;
        end
        UPD_ALU: begin
          flags_d[FLG_N] = alu_negative;
          flags_d[FLG_Z] = alu_zero;
          flags_d[FLG_C] = alu_carry;
          flags_d[FLG_V] = alu_overflow;
        end
        UPD_MOV: begin
          flags_d[FLG_N] = alu_negative;
          flags_d[FLG_Z] = alu_zero;
        end
        UPD_OVF: begin
          flags_d[FLG_V] = alu_overflow;
        end
        UPD_TRAP: begin
          push_req = 1'b1;
          if (lifo_push_ok) begin
            flags_d[FLG_M] = 1'b1;
          end
        end
        UPD_HALT: begin
          flags_d = '1;
        end
        UPD_RETURN: begin
          pop_req = 1'b1;
          if (lifo_pop_ok) begin
            flags_d = pop_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign fault_d = fault_q | (push_req & lifo_full) | (pop_req & lifo_empty);

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
      fault_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      fault_q <= fault_d;
    end
  end

  assign flags         = flags_q;
  assign negative_flag = flags_q[FLG_N];
  assign zero_flag     = flags_q[FLG_Z];
  assign carry_flag    = flags_q[FLG_C];
  assign overflow_flag = flags_q[FLG_V];
  assign mode_flag     = flags_q[FLG_M];
  assign stack_depth   = lifo_depth;
  assign stack_empty   = lifo_empty;
  assign stack_full    = lifo_full;
  assign stack_fault   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_spec_reg_stack.sv
`default_nettype none
// tb_spec_reg_stack: table-driven scoreboard bench for spec_reg_stack (DEPTH=4).
module tb_spec_reg_stack;
  import spec_reg_pkg::*;

  logic       clock;
  logic       reset;
  logic [2:0] update_mode;
  logic       wr_en;
  logic [4:0] wr_data;
  logic       alu_negative, alu_zero, alu_carry, alu_overflow;
  logic       bs_negative, bs_zero, bs_carry;
  logic       negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag;
  logic [4:0] flags;
  logic [2:0] stack_depth;
  logic       stack_empty, stack_full, stack_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [2:0] mode;
    logic       wr;
    logic [4:0] wd;
    logic [3:0] alu;
    logic [2:0] bs;
    logic [4:0] ef;
    logic [2:0] ed;
    logic       efault;
  } vec_t;

  typedef struct {
    string      tag;
    logic [4:0] ef;
    logic [2:0] ed;
    logic       efault;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[35];

  spec_reg_stack #(
    .DEPTH       (4),
    .RESET_FLAGS (5'b00000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .update_mode   (update_mode),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .bs_negative   (bs_negative),
    .bs_zero       (bs_zero),
    .bs_carry      (bs_carry),
    .negative_flag (negative_flag),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .mode_flag     (mode_flag),
    .flags         (flags),
    .stack_depth   (stack_depth),
    .stack_empty   (stack_empty),
    .stack_full    (stack_full),
    .stack_fault   (stack_fault)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1);
  end

  function automatic vec_t mk(input string tag, input logic [2:0] mode, input logic wr,
                              input logic [4:0] wd, input logic [3:0] alu, input logic [2:0] bs,
                              input logic [4:0] ef, input logic [2:0] ed, input logic efault);
    vec_t v;
    v.tag = tag; v.mode = mode; v.wr = wr; v.wd = wd; v.alu = alu; v.bs = bs;
    v.ef = ef; v.ed = ed; v.efault = efault;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, what, got, want);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp(e.tag, "flags", int'(flags), int'(e.ef));
    cmp(e.tag, "flag_pins",
        int'({negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag}), int'(e.ef));
    cmp(e.tag, "depth", int'(stack_depth), int'(e.ed));
    cmp(e.tag, "empty", int'(stack_empty), int'(e.ed == 3'd0));
    cmp(e.tag, "full", int'(stack_full), int'(e.ed == 3'd4));
    cmp(e.tag, "fault", int'(stack_fault), int'(e.efault));
  endtask

  // Drive one command before the falling edge, score it after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    update_mode = v.mode;
    wr_en       = v.wr;
    wr_data     = v.wd;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = v.alu;
    {bs_negative, bs_zero, bs_carry} = v.bs;
    sb.push_back('{v.tag, v.ef, v.ed, v.efault});
    @(negedge clock);
    @(posedge clock);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.scoreboard got=empty want=entry", v.tag);
    end else begin
      e = sb.pop_front();
      check_all(e);
    end
  endtask

  initial begin
    reset = 1'b1;
    update_mode = UPD_HOLD;
    wr_en = 1'b0;
    wr_data = 5'b0;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = 4'b0;
    {bs_negative, bs_zero, bs_carry} = 3'b0;

    tbl[0]  = mk("alu",      UPD_ALU,    0, 5'b00000, 4'b1011, 3'b000, 5'b10110, 0, 0);
    tbl[1]  = mk("bs",       UPD_BS,     0, 5'b00000, 4'b0000, 3'b010, 5'b01010, 0, 0);
    tbl[2]  = mk("hold",     UPD_HOLD,   0, 5'b00000, 4'b1111, 3'b111, 5'b01010, 0, 0);
    tbl[3]  = mk("mov",      UPD_MOV,    0, 5'b00000, 4'b1001, 3'b000, 5'b10010, 0, 0);
    tbl[4]  = mk("ovf",      UPD_OVF,    0, 5'b00000, 4'b1110, 3'b000, 5'b10000, 0, 0);
    tbl[5]  = mk("wr0",      UPD_HOLD,   1, 5'b10100, 4'b0000, 3'b000, 5'b10100, 0, 0);
    tbl[6]  = mk("trap1",    UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b10101, 1, 0);
    tbl[7]  = mk("alu_in",   UPD_ALU,    0, 5'b00000, 4'b0100, 3'b000, 5'b01001, 1, 0);
    tbl[8]  = mk("ret1",     UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b10100, 0, 0);
    tbl[9]  = mk("wr_a",     UPD_HOLD,   1, 5'b00010, 4'b0000, 3'b000, 5'b00010, 0, 0);
    tbl[10] = mk("push_a",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b00011, 1, 0);
    tbl[11] = mk("wr_b",     UPD_HOLD,   1, 5'b01000, 4'b0000, 3'b000, 5'b01000, 1, 0);
    tbl[12] = mk("push_b",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b01001, 2, 0);
    tbl[13] = mk("wr_c",     UPD_HOLD,   1, 5'b10000, 4'b0000, 3'b000, 5'b10000, 2, 0);
    tbl[14] = mk("push_c",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b10001, 3, 0);
    tbl[15] = mk("wr_d",     UPD_HOLD,   1, 5'b11100, 4'b0000, 3'b000, 5'b11100, 3, 0);
    tbl[16] = mk("push_d",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b11101, 4, 0);
    tbl[17] = mk("wr_e",     UPD_HOLD,   1, 5'b00110, 4'b0000, 3'b000, 5'b00110, 4, 0);
    tbl[18] = mk("trap_full",UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b00110, 4, 1);
    tbl[19] = mk("pop_d",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b11100, 3, 1);
    tbl[20] = mk("pop_c",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b10000, 2, 1);
    tbl[21] = mk("pop_b",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b01000, 1, 1);
    tbl[22] = mk("pop_a",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b00010, 0, 1);
    tbl[23] = mk("ret_empty",UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b00010, 0, 1);
    tbl[24] = mk("wr_over",  UPD_TRAP,   1, 5'b00111, 4'b0000, 3'b000, 5'b00111, 0, 1);
    tbl[25] = mk("halt",     UPD_HALT,   0, 5'b00000, 4'b0000, 3'b000, 5'b11111, 0, 1);
    tbl[26] = mk("wr_f",     UPD_HOLD,   1, 5'b00100, 4'b0000, 3'b000, 5'b00100, 0, 1);
    tbl[27] = mk("push_f",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b00101, 1, 1);
    tbl[28] = mk("wr_g",     UPD_HOLD,   1, 5'b11000, 4'b0000, 3'b000, 5'b11000, 1, 1);
    tbl[29] = mk("push_g",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b11001, 2, 1);
    tbl[30] = mk("pop_g",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b11000, 1, 1);
    tbl[31] = mk("wr_h",     UPD_HOLD,   1, 5'b01110, 4'b0000, 3'b000, 5'b01110, 1, 1);
    tbl[32] = mk("push_h",   UPD_TRAP,   0, 5'b00000, 4'b0000, 3'b000, 5'b01111, 2, 1);
    tbl[33] = mk("pop_h",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b01110, 1, 1);
    tbl[34] = mk("pop_f",    UPD_RETURN, 0, 5'b00000, 4'b0000, 3'b000, 5'b00100, 0, 1);

    repeat (2) @(posedge clock);
    check_all('{"reset", 5'b00000, 3'd0, 1'b0});
    #1 reset = 1'b0;

    for (int i = 0; i < 35; i++) begin
      apply(tbl[i]);
    end

    // Asynchronous reset between edges with two contexts saved and fault set.
    apply(mk("pre_rst1", UPD_TRAP, 0, 5'b0, 4'b0, 3'b0, 5'b00101, 1, 1));
    apply(mk("pre_rst2", UPD_TRAP, 0, 5'b0, 4'b0, 3'b0, 5'b00101, 2, 1));
    update_mode = UPD_HOLD;
    #1 reset = 1'b1;
    #1 check_all('{"async_rst", 5'b00000, 3'd0, 1'b0});
    @(negedge clock);
    @(posedge clock);
    check_all('{"rst_hold", 5'b00000, 3'd0, 1'b0});
    #1 reset = 1'b0;

    // After release: write masks an illegal pop, then a real pop faults.
    apply(mk("wr_mask",  UPD_RETURN, 1, 5'b01010, 4'b0,    3'b0, 5'b01010, 0, 0));
    apply(mk("ret_rst",  UPD_RETURN, 0, 5'b0,     4'b0,    3'b0, 5'b01010, 0, 1));
    apply(mk("trap_ok",  UPD_TRAP,   0, 5'b0,     4'b0,    3'b0, 5'b01011, 1, 1));
    apply(mk("alu_zero", UPD_ALU,    0, 5'b0,     4'b0000, 3'b0, 5'b00001, 1, 1));
    apply(mk("ret_ok",   UPD_RETURN, 0, 5'b0,     4'b0,    3'b0, 5'b01010, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spec_reg_stack.md
# spec_reg_stack

Parametrised successor to the control unit's special (status) register. It holds the N/Z/C/V flags and the mode flag M, and updates them from the ALU or barrel shifter under a 3-bit `update_mode` command. It adds a hardware LIFO that saves flags on trap entry and restores them on return, a direct write path for context switches, and stack occupancy and fault status. It sits in the control unit between the ALU/shifter flag outputs and the condition-evaluation and interrupt logic.

## Interface
- `DEPTH`, default 4: number of saved flag contexts (≥1).
- `RESET_FLAGS`, default 5'b00000: value loaded into {N,Z,C,V,M} on reset.

Ports (flag-vector order is always {N,Z,C,V,M}, bit 4 down to bit 0):
- `clock`  in  1: single clock; all state updates on the falling edge.
- `reset`  in  1: asynchronous, active-high.
- `update_mode`  in  3: command, encoding below.
- `wr_en`  in  1: direct load of the flag vector.
- `wr_data`  in  5: value for the direct load.
- `alu_negative`, `alu_zero`, `alu_carry`, `alu_overflow`  in  1 each: ALU flags.
- `bs_negative`, `bs_zero`, `bs_carry`  in  1 each: barrel-shifter flags.
- `negative_flag`, `zero_flag`, `carry_flag`, `overflow_flag`, `mode_flag`  out  1 each: current flags.
- `flags`  out  5: the same five flags as one vector.
- `stack_depth`  out  $clog2(DEPTH+1): number of saved contexts.
- `stack_empty`, `stack_full`  out  1 each: occupancy == 0 and occupancy == DEPTH.
- `stack_fault`  out  1: sticky error; cleared only by reset.

## Operation
Commands (`update_mode`):
- 0 HOLD: no change.
- 1 BS: {N,Z,C} ← bs flags.
- 2 ALU: {N,Z,C,V} ← alu flags.
- 3 MOV: {N,Z} ← alu flags.
- 4 OVF: V ← alu_overflow.
- 5 TRAP: push the current 5-bit vector; M ← 1. N, Z, C and V are unchanged.
- 6 HALT: all five flags ← 1.
- 7 RETURN: pop; the flag vector ← popped entry.

Flags not named by a command keep their value.

Priority is reset > `wr_en` > `update_mode`. When `wr_en`=1 the command is ignored that cycle, including any push or pop.

Boundary cases:
- TRAP when full: no push, flags unchanged (M is not set), `stack_fault` ← 1.
- RETURN when empty: no pop, flags unchanged, `stack_fault` ← 1.
- Stack contents are not cleared on pop; entries above the top are don't-care.
- Reset mid-operation: flags ← RESET_FLAGS, depth ← 0, fault ← 0. Stack storage is not cleared.

## Timing
- Every command and direct write takes effect on the falling edge of `clock` at which it is sampled. Flag outputs are visible from that edge and stay stable for a full cycle.
- All outputs are register-driven. There is no combinational path from any input to any output.
- Reset values: `flags` = RESET_FLAGS, `stack_depth` = 0, `stack_empty` = 1, `stack_full` = 0, `stack_fault` = 0.
- Reset is asserted asynchronously; release is synchronised by the surrounding reset logic.
- `stack_empty` and `stack_full` are derived from the registered depth, so they are valid in the same cycle as `stack_depth`.
- Back-to-back TRAP then RETURN on consecutive edges is legal. The RETURN pops the value pushed one edge earlier.
- A TRAP in the cycle after RETURN reuses the freed slot.
- Latency is one edge for all commands; no command takes multiple cycles.

## Structure
- Shared package `spec_reg_pkg`:
  - mode encodings `UPD_HOLD` through `UPD_RETURN`;
  - flag bit indices `FLG_N=4`, `FLG_Z=3`, `FLG_C=2`, `FLG_V=1`, `FLG_M=0`;
  - `FLAG_W=5`.
- Sub-module `flag_lifo`:
  - DEPTH×5 storage, depth counter, and push/pop ports;
  - exports full/empty, and accepts push/pop only when legal.
- The top level contains:
  - the command decoder;
  - the flag register;
  - the fault logic, which sets `stack_fault` on a requested-but-illegal push or pop.

## Test plan
- Reset, then ALU command with alu NZCV = 1,0,1,1 → `flags` = 5'b10110 at the next falling edge. Then BS command with bs NZC = 0,1,0 → `flags` = 5'b01010 (V retained).
- With `flags` = 5'b10100: TRAP → `flags` = 5'b10101, depth 1. ALU command with alu NZCV = 0,1,0,0 → `flags` = 5'b01001. RETURN → `flags` = 5'b10100, depth 0, `stack_empty` = 1.
- DEPTH=4: five TRAPs with distinct flag values loaded via `wr_en` between them → depth 4, `stack_full` = 1, and the fifth TRAP leaves flags unchanged and sets `stack_fault`. Four RETURNs restore the values in LIFO order.
- RETURN on an empty stack → flags unchanged, `stack_fault` = 1, and it stays 1 through subsequent legal commands until reset.
- `wr_en`=1 with `wr_data` = 5'b00111 while `update_mode`=5 → `flags` = 5'b00111 and depth unchanged. HALT → `flags` = 5'b11111.
- Assert `reset` between clock edges with depth 2 and fault set → outputs reach their reset values immediately, without waiting for a clock edge. A RETURN after release → fault set (stack empty).
